// File: rtl/decode_register_file_pkg.sv
// Shared register-file constants used by the decoder, hazard unit and register file.
package decode_register_file_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/decode_register_file_load_use_detector.sv
// Combinational load-use hazard compare between the load in EX and the sources read in ID.
module load_use_detector #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  ex_mem_read_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    output logic                  stall_o
);
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
        // x0 never carries a loaded value, so it cannot create a hazard
        stall_o = ex_mem_read_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);
    end
endmodule

// File: rtl/decode_register_file.sv
// Architectural integer register file: two write-first bypassed read ports, one write port,
// committed-write counter and load-use stall request.
module decode_register_file #(
    parameter int DATA_WIDTH = decode_register_file_pkg::DATA_WIDTH,
    parameter int REG_COUNT  = decode_register_file_pkg::REG_COUNT,
    parameter int ADDR_WIDTH = decode_register_file_pkg::REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ID_rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] ID_rs2_addr_i,
    input  logic                  ID_rs1_used_i,
    input  logic                  ID_rs2_used_i,
    output logic [DATA_WIDTH-1:0] ID_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ID_rs2_data_o,
    input  logic                  EX_mem_read_i,
    input  logic [ADDR_WIDTH-1:0] EX_rd_addr_i,
    input  logic                  WB_reg_write_i,
    input  logic [ADDR_WIDTH-1:0] WB_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] WB_writeback_data_i,
    output logic                  ID_load_use_stall_o,
    output logic [31:0]           RF_write_count_o
);
    import decode_register_file_pkg::*;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT-1:1];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT-1:1];
    logic [31:0]           count_q;
    logic [31:0]           count_d;
    logic                  wr_commit;

    // Reset also blocks the bypass so reads are 0 for the whole time rst is high
    assign wr_commit = !rst && WB_reg_write_i && (WB_rd_addr_i != ADDR_WIDTH'(ZERO_REG));

    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (wr_commit && (WB_rd_addr_i == ADDR_WIDTH'(i))) begin
                regs_d[i] = WB_writeback_data_i;
            end
        end
        if (wr_commit) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        ID_rs1_data_o = '0;
        ID_rs2_data_o = '0;
        if (ID_rs1_addr_i != '0) begin
            if (wr_commit && (WB_rd_addr_i == ID_rs1_addr_i)) ID_rs1_data_o = WB_writeback_data_i;
            else                                              ID_rs1_data_o = regs_q[ID_rs1_addr_i];
        end
        if (ID_rs2_addr_i != '0) begin
            if (wr_commit && (WB_rd_addr_i == ID_rs2_addr_i)) ID_rs2_data_o = WB_writeback_data_i;
            else                                              ID_rs2_data_o = regs_q[ID_rs2_addr_i];
        end
    end

    assign RF_write_count_o = count_q;

    load_use_detector #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_load_use_detector (
        .ex_mem_read_i(EX_mem_read_i),
        .ex_rd_addr_i (EX_rd_addr_i),
        .id_rs1_addr_i(ID_rs1_addr_i),
        .id_rs2_addr_i(ID_rs2_addr_i),
        .id_rs1_used_i(ID_rs1_used_i),
        .id_rs2_used_i(ID_rs2_used_i),
        .stall_o      (ID_load_use_stall_o)
    );
endmodule

// File: tb/tb_decode_register_file.sv
// Scoreboard bench: the driver pushes expectations from an array model, a negedge monitor checks.
module tb_decode_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd, wb_rd;
    logic        rs1_used, rs2_used, mem_read, wb_we;
    logic [31:0] wb_data;
    logic [31:0] rs1_data, rs2_data, wcount;
    logic        stall;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        stall;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];
    logic [31:0] mdl_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    decode_register_file dut (
        .clk(clk), .rst(rst),
        .ID_rs1_addr_i(rs1_addr), .ID_rs2_addr_i(rs2_addr),
        .ID_rs1_used_i(rs1_used), .ID_rs2_used_i(rs2_used),
        .ID_rs1_data_o(rs1_data), .ID_rs2_data_o(rs2_data),
        .EX_mem_read_i(mem_read), .EX_rd_addr_i(ex_rd),
        .WB_reg_write_i(wb_we), .WB_rd_addr_i(wb_rd), .WB_writeback_data_i(wb_data),
        .ID_load_use_stall_o(stall), .RF_write_count_o(wcount)
    );

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Architectural read: x0 is 0, a live write to the same index is seen now, else stored value
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (!rst && wb_we && wb_rd == a) return wb_data;
        return mdl[a];
    endfunction

    // Drive one cycle (inputs already set), push the expectation, then advance the model at the edge
    task automatic step(input string tag);
        exp_t e;
        if (rst) begin
            foreach (mdl[i]) mdl[i] = 32'h0;
            mdl_cnt = 32'h0;
        end
        e.rs1   = model_read(rs1_addr);
        e.rs2   = model_read(rs2_addr);
        e.stall = mem_read && ex_rd != 5'd0 &&
                  ((rs1_used && rs1_addr == ex_rd) || (rs2_used && rs2_addr == ex_rd));
        e.cnt   = mdl_cnt;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        if (!rst && wb_we && wb_rd != 5'd0) begin
            mdl[wb_rd] = wb_data;
            mdl_cnt    = mdl_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic set_wr(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we = we; wb_rd = rd; wb_data = d;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rs1_data", e.tag, rs1_data, e.rs1);
            chk("rs2_data", e.tag, rs2_data, e.rs2);
            chk("stall", e.tag, {31'h0, stall}, {31'h0, e.stall});
            chk("write_count", e.tag, wcount, e.cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (mdl[i]) mdl[i] = 32'h0;
        mdl_cnt  = 32'h0;
        rst      = 1'b1;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        mem_read = 1'b0; ex_rd = 5'd0;
        set_wr(1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        step("in_reset");
        rst = 1'b0;

        // Every index reads 0 after reset on both ports
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            step("reset_scan");
        end

        rs1_addr = 5'd5; rs2_addr = 5'd0;
        set_wr(1'b1, 5'd5, 32'hDEAD_BEEF); step("x5_bypass");
        set_wr(1'b0, 5'd5, 32'h0);         step("x5_stored");

        rs1_addr = 5'd0; rs2_addr = 5'd0;
        set_wr(1'b1, 5'd0, 32'h1234_5678); step("x0_write");
        set_wr(1'b0, 5'd0, 32'h1234_5678); step("x0_after");

        mem_read = 1'b1; ex_rd = 5'd7; rs2_addr = 5'd7; rs2_used = 1'b1;
        step("stall_hit");
        rs2_used = 1'b0; step("stall_unused");
        rs2_used = 1'b1; ex_rd = 5'd0; rs2_addr = 5'd0; step("stall_x0");
        mem_read = 1'b0; rs2_used = 1'b0;

        rs1_addr = 5'd3; rs2_addr = 5'd3;
        set_wr(1'b1, 5'd3, 32'hAAAA_AAAA); step("x3_first");
        set_wr(1'b1, 5'd3, 32'h5555_5555); step("x3_second");
        set_wr(1'b0, 5'd3, 32'h0);         step("x3_final");

        rs1_addr = 5'd9;
        set_wr(1'b1, 5'd9, 32'hFFFF_FFFF); step("x9_write");
        rst = 1'b1;                        step("x9_reset");
        rst = 1'b0; set_wr(1'b0, 5'd9, 32'h0); step("x9_released");

        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            rs1_used = 1'($urandom_range(0, 1));
            rs2_used = 1'($urandom_range(0, 1));
            mem_read = 1'($urandom_range(0, 1));
            ex_rd    = ($urandom_range(0, 2) == 0) ? rs2_addr : 5'($urandom_range(0, 31));
            set_wr(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0) ? rs1_addr : 5'($urandom_range(0, 31)),
                   $urandom);
            step("random");
        end
        rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_register_file.md
# decode_register_file

Architectural integer register file for the 5-stage core. It sits in the decode stage and receives the value produced by `writeback_stage`, driven through `WB_reg_write_i`, `WB_rd_addr_i` and `WB_writeback_data_i`. It supplies the two source operands to decode, with same-cycle write-to-read bypass. It also raises the load-use stall request consumed by the hazard/pipeline-control logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32 (from `defines`), register width.
- `REG_COUNT`, 32, number of architectural registers.
- `ADDR_WIDTH`, 5, register index width; must equal clog2(`REG_COUNT`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ID_rs1_addr_i`  in  ADDR_WIDTH  source register 1 index.
- `ID_rs2_addr_i`  in  ADDR_WIDTH  source register 2 index.
- `ID_rs1_used_i`  in  1  instruction in ID actually reads rs1.
- `ID_rs2_used_i`  in  1  instruction in ID actually reads rs2.
- `ID_rs1_data_o`  out  DATA_WIDTH  operand 1.
- `ID_rs2_data_o`  out  DATA_WIDTH  operand 2.
- `EX_mem_read_i`  in  1  instruction in EX is a load.
- `EX_rd_addr_i`  in  ADDR_WIDTH  destination of instruction in EX.
- `WB_reg_write_i`  in  1  write enable from writeback.
- `WB_rd_addr_i`  in  ADDR_WIDTH  writeback destination.
- `WB_writeback_data_i`  in  DATA_WIDTH  value selected by writeback.
- `ID_load_use_stall_o`  out  1  request to hold PC/IF-ID and bubble ID-EX.
- `RF_write_count_o`  out  32  count of committed register writes (debug/perf).

## Operation
- Storage: `REG_COUNT` x `DATA_WIDTH` flops. Entry 0 is not stored; reads of index 0 return 0.
- Write: on a rising edge with `WB_reg_write_i`=1 and `WB_rd_addr_i`≠0, `regs[WB_rd_addr_i]` takes `WB_writeback_data_i`. A write to x0 is discarded and not counted.
- Read, per port, combinational, priority order:
  - address 0 returns 0;
  - else if `WB_reg_write_i` and `WB_rd_addr_i` equals the address, return `WB_writeback_data_i` (write-first bypass);
  - else return the stored value.
- Both ports are independent. Identical rs1/rs2 addresses return identical data.
- Load-use stall: `ID_load_use_stall_o` = `EX_mem_read_i` && `EX_rd_addr_i`≠0 && ((`ID_rs1_used_i` && `ID_rs1_addr_i`==`EX_rd_addr_i`) || (`ID_rs2_used_i` && `ID_rs2_addr_i`==`EX_rd_addr_i`)). Purely combinational. The block holds no stall state; pipeline control owns the bubble.
- Write counter: `RF_write_count_o` increments by 1 on each committed write, i.e. the enable is set and the address is nonzero. It wraps from 0xFFFF_FFFF to 0 with no flag.
- No X propagation: unused/undriven inputs must not make read data X when the corresponding address is 0.

## Timing
- Reset (async assert, released synchronously by the system): all registers become 0, `RF_write_count_o` becomes 0. Read data reflects 0 immediately while `rst` is high. `ID_load_use_stall_o` follows its inputs during reset.
- A write issued in cycle N is visible on the read ports in cycle N through the bypass, and from storage in N+1 onward.
- Stall output: zero latency from the EX/ID inputs.
- `rst` asserted in the same cycle as a write: reset wins; the register and the counter stay 0.
- Back-to-back writes to the same index: the last one wins. Each write is counted.

## Structure
- Use `DATA_WIDTH` from `defines`. Add `REG_COUNT`, `REG_ADDR_WIDTH` and `ZERO_REG` (5'd0) to `defines` so the decoder and the hazard unit share them.
- One natural sub-module: `load_use_detector`, the combinational stall compare, which is reusable by pipeline control. Storage, bypass and the counter stay in the top module.

## Test plan
- Reset, then read all 32 indices on both ports → every read returns 0x0000_0000 and `RF_write_count_o`=0.
- Write x5=0xDEAD_BEEF while reading rs1=5 in the same cycle → `ID_rs1_data_o`=0xDEAD_BEEF in that cycle; the next cycle, with write enable low, still 0xDEAD_BEEF; count=1.
- Write x0=0x1234_5678 while reading rs1=rs2=0 → both outputs 0 in that cycle and the next; count unchanged.
- `EX_mem_read_i`=1, `EX_rd_addr_i`=7, rs2=7 with `ID_rs2_used_i`=1 → stall=1. Drop `ID_rs2_used_i` → stall=0. Set `EX_rd_addr_i`=0 → stall=0.
- Write x3=0xAAAA_AAAA, then x3=0x5555_5555 on consecutive cycles → reads show 0xAAAA_AAAA then 0x5555_5555; count=2.
- Write x9=0xFFFF_FFFF, then assert `rst` mid-cycle with `WB_reg_write_i`=1 to x9 → x9 reads 0 immediately and after release; count=0.
